pll_clken_gen: RTL and testbench
================================

# pll_clken_gen

Multi-channel clock-enable generator and reset sequencer that sits directly behind the system PLL. It filters the PLL `locked` indication and holds downstream logic in reset until lock has been stable for a programmable time. It then produces NUM_CH independently programmable clock-enable pulses and divided square clocks, all in the PLL output domain. This replaces ad-hoc per-peripheral dividers (UART baud, timers) with one runtime-reprogrammable block.

## Interface
- `NUM_CH`, 2: number of divider channels (1..8)
- `DIV_W`, 16: width of each channel's divide and phase fields
- `LOCK_CYCLES`, 1024: consecutive synchronised-lock cycles required before release (≥2)
- `DIV_RST`, 2: divide value loaded into every channel on reset

- `refclk` in 1: the single clock for the block (PLL output clock)
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: asynchronous PLL lock indication; double-flop synchronised internally to `lock_s`
- `div` in NUM_CH*DIV_W: per-channel divide value D; channel i occupies bits [i*DIV_W +: DIV_W]
- `phase` in NUM_CH*DIV_W: per-channel start count P, same packing
- `load` in 1: single-cycle strobe that captures `div` and `phase`
- `clken` out NUM_CH: registered one-cycle enable pulse per channel
- `sqclk` out NUM_CH: registered divided clock; toggles on each `clken` pulse, so its period is 2·D′
- `locked` out 1: filtered lock status
- `rst_out` out 1: registered active-high reset for downstream logic

## Operation
- D′ = max(D,1). Values D=0 and D=1 both give a `clken` pulse every cycle.
- P′ = P if P < D′, else 0.
- FSM states are S_RESET, S_WAIT, S_COUNT and S_RUN.
  - S_RESET: entered while `rst`=1. Leaves to S_WAIT on the first edge with `rst`=0.
  - S_WAIT: `lock_cnt`=0. Moves to S_COUNT when `lock_s`=1.
  - S_COUNT: `lock_cnt` increments each cycle. If `lock_s`=0, returns to S_WAIT. When `lock_cnt`=LOCK_CYCLES−1, moves to S_RUN.
  - S_RUN: if `lock_s`=0, moves to S_WAIT.
- Outputs are Moore outputs decoded from the registered state:
  - `locked`=1 only in S_RUN.
  - `rst_out`=0 only in S_RUN.
- Channel counters:
  - Outside S_RUN: `cnt_i` is held at P′ and `clken`/`sqclk` are forced to 0.
  - In S_RUN: if `cnt_i`=D′−1, `cnt_i` wraps to 0, else it increments. `clken_i` is registered as (`cnt_i`=D′−1). `sqclk_i` toggles whenever `clken_i` is set.
- Load:
  - `load`=1 captures `div` and `phase` in every state except S_RESET.
  - If the block is in S_RUN and stays there, the same edge reloads `cnt_i` to the new P′ and clears `clken_i`. `sqclk_i` keeps its level.
- Simultaneous events:
  - `rst` overrides everything.
  - Lock loss overrides `load` for counters and outputs, but the div/phase capture still happens.
- Reset values:
  - `clken`=0, `sqclk`=0, `locked`=0, `rst_out`=1.
  - Div registers = DIV_RST, phase registers = 0, counters = 0, synchroniser flops = 0.
- Reset mid-operation: the next edge returns every output to its reset value.

## Timing
- The synchroniser adds 2 `refclk` edges of latency on `pll_locked`.
- With `pll_locked` high and stable, `locked`↑ and `rst_out`↓ occur LOCK_CYCLES+3 edges after `pll_locked` is first sampled high.
- On the edge that enters S_RUN, `cnt_i`=P′. The first `clken_i` pulse follows D′−P′ edges later, and pulses then repeat every D′ edges.
- After a `load` in S_RUN, the first pulse follows D′new−P′new edges after the load edge.
- A `lock_s` low for a single cycle in S_COUNT restarts the full LOCK_CYCLES filter.
- Lock loss in S_RUN: `locked`↓, `rst_out`↑ and `clken`=0 take effect 3 edges after the `pll_locked` fall.

## Configuration
- `PLL_CLKEN_PHASE_EN`
  - Defined: the `phase` port is honoured as described above.
  - Undefined: the `phase` input is ignored and P′=0 for all channels. Phase registers are not synthesised.

## Test plan
- Reset and release, with LOCK_CYCLES=16 and `pll_locked` tied to 1 from `rst`↓: `rst_out` stays 1 for exactly 19 edges, then drops to 0; `locked`=1.
- Lock glitch, with `pll_locked` low for 1 cycle during S_COUNT: the release edge slips by the full filter length from the glitch recovery, and `rst_out` never drops early.
- Channel 0 with D=4, P=0 and channel 1 with D=1: `clken[0]` pulses every 4 edges; `clken[1]` stays high continuously; `sqclk[0]` has a period of 8 edges at 50% duty.
- Phase, with `PLL_CLKEN_PHASE_EN` defined, D=5 and P=3: the first pulse comes 2 edges after S_RUN entry. With P=7 (≥D), the first pulse comes after 5 edges. With the macro undefined, it comes after 5 edges in both cases.
- Runtime load in S_RUN, changing D from 4 to 10 with P=0 mid-count: no pulse within 9 edges of the load, a pulse on the 10th edge, then pulses every 10 edges.
- Lock loss with a simultaneous `load` in S_RUN: 3 edges later `clken`=0, `sqclk`=0, `rst_out`=1. After re-lock, the channel runs with the newly loaded D.

Source files
------------

// File: rtl/pll_clken_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_clken_gen_if                                             |
// | Description : Signal bundle between the PLL clock-enable generator and its |
// |               environment. Carries the raw PLL lock indication, the       |
// |               per-channel divide/phase programming, the load strobe and   |
// |               all generated enables, divided clocks and reset outputs.    |
// | Ports       : pll_locked  - asynchronous PLL lock indication             |
// |               div         - NUM_CH x DIV_W packed divide values          |
// |               phase       - NUM_CH x DIV_W packed start counts           |
// |               load        - single-cycle capture strobe for div/phase    |
// |               clken       - per-channel one-cycle enable pulses          |
// |               sqclk       - per-channel divided square clocks            |
// |               locked      - filtered lock status                         |
// |               rst_out     - active-high reset for downstream logic       |
// | Modports    : master (environment side), slave (generator side)          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pll_clken_gen_if #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 16
);
   logic                      pll_locked;
   logic [NUM_CH*DIV_W-1:0]   div;
   logic [NUM_CH*DIV_W-1:0]   phase;
   logic                      load;
   logic [NUM_CH-1:0]         clken;
   logic [NUM_CH-1:0]         sqclk;
   logic                      locked;
   logic                      rst_out;

   modport master (
      output pll_locked, div, phase, load,
      input  clken, sqclk, locked, rst_out
   );

   modport slave (
      input  pll_locked, div, phase, load,
      output clken, sqclk, locked, rst_out
   );
endinterface
`default_nettype wire

// File: rtl/pll_clken_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_clken_gen                                                |
// | Description : Multi-channel clock-enable generator and reset sequencer     |
// |               behind the system PLL. Synchronises and filters the PLL     |
// |               lock indication, holds downstream logic in reset until lock |
// |               has been stable for LOCK_CYCLES cycles, then produces       |
// |               NUM_CH runtime-programmable enable pulses and divided       |
// |               square clocks.                                              |
// | Ports       : refclk - PLL output clock, the only clock of the block      |
// |               rst    - synchronous active-high reset                      |
// |               bus    - pll_clken_gen_if.slave (lock input, div/phase/load |
// |                        programming, clken/sqclk/locked/rst_out outputs)   |
// | Options     : PLL_CLKEN_PHASE_EN - when defined, the per-channel phase    |
// |               field sets the counter start value; when undefined the     |
// |               phase input is ignored and every channel starts at 0.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_clken_gen #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 16,
   parameter int LOCK_CYCLES = 1024,
   parameter int DIV_RST     = 2
) (
   input  logic              refclk,
   input  logic              rst,
   pll_clken_gen_if.slave    bus
);

   localparam int                 LCNT_W    = $clog2(LOCK_CYCLES);
   localparam logic [LCNT_W-1:0]  LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);
   localparam logic [LCNT_W-1:0]  LCNT_ONE  = LCNT_W'(1);
   localparam logic [DIV_W-1:0]   DIV_RST_V = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_WAIT  = 2'd1,
      S_COUNT = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   // Effective divide: 0 and 1 both mean "pulse every cycle".
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_ONE : d;
   endfunction

   // -------------------------------------------------------------------------
   // Lock synchroniser
   // -------------------------------------------------------------------------
   logic sync1_q;
   logic lock_s_q;

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= bus.pll_locked;
         lock_s_q <= sync1_q;
      end
   end

   // -------------------------------------------------------------------------
   // Lock filter / reset sequencer FSM
   // -------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic               locked_q;
   logic               rst_out_q;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q    <= S_RESET;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         rst_out_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         // Registered copies of the S_RUN decode so the downstream reset
         // comes straight from a flop and cannot glitch.
         locked_q   <= (state_d == S_RUN);
         rst_out_q  <= (state_d != S_RUN);
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = '0;
      unique case (state_q)
         S_RESET: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lock_s_q) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            // Any low cycle drops back to S_WAIT and clears the count, so a
            // single-cycle glitch restarts the whole filter.
            if (!lock_s_q) begin
               state_d = S_WAIT;
            end else if (lock_cnt_q == LCNT_LAST) begin
               state_d = S_RUN;
            end else begin
               lock_cnt_d = lock_cnt_q + LCNT_ONE;
            end
         end
         S_RUN: begin
            if (!lock_s_q) begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   assign bus.locked  = locked_q;
   assign bus.rst_out = rst_out_q;

   // -------------------------------------------------------------------------
   // Shared channel control
   // -------------------------------------------------------------------------
   logic load_acc;
   logic run_now;
   logic run_next;

   assign load_acc = bus.load && (state_q != S_RESET);
   assign run_now  = (state_q == S_RUN);
   assign run_next = (state_d == S_RUN);

`ifndef PLL_CLKEN_PHASE_EN
   // Phase programming is not used in this build.
   logic phase_unused;
   assign phase_unused = ^bus.phase;
`endif

   logic [NUM_CH-1:0] clken_vec;
   logic [NUM_CH-1:0] sqclk_vec;

   // -------------------------------------------------------------------------
   // Divider channels
   // -------------------------------------------------------------------------
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [DIV_W-1:0] div_q, div_d;
      logic [DIV_W-1:0] dp_q;       // effective divide in use this cycle
      logic [DIV_W-1:0] dp_next;    // effective divide after this edge
      logic [DIV_W-1:0] pp_next;    // effective start count after this edge
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             clken_q, clken_d;
      logic             sq_q, sq_d;
      logic             wrap;

      assign div_d   = load_acc ? bus.div[ch*DIV_W +: DIV_W] : div_q;
      assign dp_q    = eff_div(div_q);
      assign dp_next = eff_div(div_d);

`ifdef PLL_CLKEN_PHASE_EN
      logic [DIV_W-1:0] phase_q, phase_d;

      assign phase_d = load_acc ? bus.phase[ch*DIV_W +: DIV_W] : phase_q;
      // An out-of-range start count falls back to 0.
      assign pp_next = (phase_d < dp_next) ? phase_d : '0;

      always_ff @(posedge refclk) begin
         if (rst) begin
            phase_q <= '0;
         end else begin
            phase_q <= phase_d;
         end
      end
`else
      assign pp_next = '0;
`endif

      assign wrap = (cnt_q == (dp_q - DIV_ONE));

      // Start values are taken from the post-edge div/phase so that a load
      // coinciding with S_RUN entry or with lock loss lands consistently.
      always_comb begin
         cnt_d   = cnt_q;
         clken_d = 1'b0;
         sq_d    = sq_q;
         if (!run_next) begin
            cnt_d = pp_next;
            sq_d  = 1'b0;
         end else if (!run_now || load_acc) begin
            // S_RUN entry or runtime reload: restart from the start count,
            // keeping the square clock at its current level.
            cnt_d = pp_next;
         end else begin
            clken_d = wrap;
            sq_d    = sq_q ^ wrap;
            cnt_d   = wrap ? '0 : (cnt_q + DIV_ONE);
         end
      end

      always_ff @(posedge refclk) begin
         if (rst) begin
            div_q   <= DIV_RST_V;
            cnt_q   <= '0;
            clken_q <= 1'b0;
            sq_q    <= 1'b0;
         end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            clken_q <= clken_d;
            sq_q    <= sq_d;
         end
      end

      assign clken_vec[ch] = clken_q;
      assign sqclk_vec[ch] = sq_q;
   end

   assign bus.clken = clken_vec;
   assign bus.sqclk = sqclk_vec;

endmodule
`default_nettype wire

// File: tb/tb_pll_clken_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_clken_gen                                             |
// | Description : Self-checking bench for pll_clken_gen. Expected pulse trains |
// |               are computed arithmetically from the run-start edge, the   |
// |               effective divide and the effective start count.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pll_clken_gen;
   localparam int NUM_CH      = 2;
   localparam int DIV_W       = 16;
   localparam int LOCK_CYCLES = 16;
   localparam int DIV_RST     = 2;
`ifdef PLL_CLKEN_PHASE_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   logic refclk = 1'b0;
   logic rst;

   pll_clken_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

   pll_clken_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .DIV_RST     (DIV_RST)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 refclk = ~refclk;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   // Reference model: channel pulses are a pure function of elapsed edges.
   bit m_run;
   int m_start [NUM_CH];
   int m_D     [NUM_CH];
   int m_P     [NUM_CH];
   bit m_sqb   [NUM_CH];

   function automatic int eff_d(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int eff_p(input int p, input int d);
      return (PHASE_EN && (p < d)) ? p : 0;
   endfunction

   function automatic int n_pulses(input int ch);
      int k;
      int f;
      k = edge_n - m_start[ch];
      f = m_D[ch] - m_P[ch];
      if (!m_run || k < f) return 0;
      return (k - f) / m_D[ch] + 1;
   endfunction

   function automatic bit exp_clken(input int ch);
      int k;
      int f;
      k = edge_n - m_start[ch];
      f = m_D[ch] - m_P[ch];
      if (!m_run) return 1'b0;
      return (k >= f) && (((k - f) % m_D[ch]) == 0);
   endfunction

   function automatic bit exp_sq(input int ch);
      int n;
      if (!m_run) return 1'b0;
      n = n_pulses(ch);
      return m_sqb[ch] ^ n[0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
      edge_n++;
   endtask

   task automatic check_all(input string tag);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         chk($sformatf("%s_clken%0d", tag, ch), 32'(bus.clken[ch]), 32'(exp_clken(ch)));
         chk($sformatf("%s_sqclk%0d", tag, ch), 32'(bus.sqclk[ch]), 32'(exp_sq(ch)));
      end
      chk({tag, "_locked"},  32'(bus.locked),  32'(m_run));
      chk({tag, "_rst_out"}, 32'(bus.rst_out), 32'(!m_run));
   endtask

   task automatic run_check(input int n, input string tag);
      repeat (n) begin
         step();
         check_all(tag);
      end
   endtask

   task automatic set_prog(input int d0, input int p0, input int d1, input int p1);
      logic [NUM_CH*DIV_W-1:0] dv;
      logic [NUM_CH*DIV_W-1:0] pv;
      dv = {DIV_W'(d1), DIV_W'(d0)};
      pv = {DIV_W'(p1), DIV_W'(p0)};
      bus.div   = dv;
      bus.phase = pv;
      m_D[0] = eff_d(d0);
      m_P[0] = eff_p(p0, m_D[0]);
      m_D[1] = eff_d(d1);
      m_P[1] = eff_p(p1, m_D[1]);
   endtask

   // Load while running: the square clock level before the edge is kept.
   task automatic load_run(input int d0, input int p0, input int d1, input int p1,
                           input string tag);
      for (int ch = 0; ch < NUM_CH; ch++) m_sqb[ch] = exp_sq(ch);
      set_prog(d0, p0, d1, p1);
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) m_start[ch] = edge_n;
      check_all(tag);
   endtask

   initial begin
      int rel;
      int d0, p0, d1, p1, mx;

      rst            = 1'b1;
      bus.pll_locked = 1'b0;
      bus.load       = 1'b0;
      bus.div        = '0;
      bus.phase      = '0;
      m_run          = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_start[ch] = 0;
         m_D[ch]     = DIV_RST;
         m_P[ch]     = 0;
         m_sqb[ch]   = 1'b0;
      end

      // Reset state
      repeat (3) step();
      chk("reset_clken",   32'(bus.clken),   32'd0);
      chk("reset_sqclk",   32'(bus.sqclk),   32'd0);
      chk("reset_locked",  32'(bus.locked),  32'd0);
      chk("reset_rst_out", 32'(bus.rst_out), 32'd1);

      // Release with lock tied high from reset deassertion
      rst            = 1'b0;
      bus.pll_locked = 1'b1;
      edge_n         = 0;
      for (int e = 1; e <= LOCK_CYCLES + 3; e++) begin
         step();
         chk("rel_rst_out", 32'(bus.rst_out), 32'(e < LOCK_CYCLES + 3));
         chk("rel_locked",  32'(bus.locked),  32'(e >= LOCK_CYCLES + 3));
         chk("rel_clken",   32'(bus.clken),   32'd0);
      end
      m_run = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) m_start[ch] = edge_n;
      run_check(8, "divrst");

      // D=4 on channel 0, D=1 on channel 1
      load_run(4, 0, 1, 0, "d4d1_ld");
      run_check(20, "d4d1");

      // Randomised reprogramming
      repeat (4) begin
         d0 = int'($urandom_range(0, 12));
         p0 = int'($urandom_range(0, 15));
         d1 = int'($urandom_range(0, 12));
         p1 = int'($urandom_range(0, 15));
         mx = (eff_d(d0) > eff_d(d1)) ? eff_d(d0) : eff_d(d1);
         load_run(d0, p0, d1, p1, "rnd_ld");
         run_check(3 * mx + 4, "rnd");
      end

      // Start count in range and out of range
      load_run(5, 3, 5, 7, "phase_ld");
      run_check(12, "phase");

      // Runtime reload from D=4 to D=10 mid-count
      load_run(4, 0, 4, 0, "mid_ld4");
      run_check(6, "mid4");
      load_run(10, 0, 10, 0, "mid_ld10");
      run_check(25, "d10");

      // Lock loss with a simultaneous load on the exit edge
      bus.pll_locked = 1'b0;
      run_check(2, "loss_pre");
      set_prog(3, 1, 6, 2);
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      m_run    = 1'b0;
      check_all("loss");
      repeat (4) begin
         step();
         check_all("loss_wait");
      end

      // Re-lock with a one-cycle glitch during the filter count
      bus.pll_locked = 1'b1;
      repeat (8) begin
         step();
         chk("glitch_pre_rst_out", 32'(bus.rst_out), 32'd1);
      end
      bus.pll_locked = 1'b0;
      step();
      chk("glitch_rst_out", 32'(bus.rst_out), 32'd1);
      bus.pll_locked = 1'b1;
      rel = edge_n + LOCK_CYCLES + 3;
      while (edge_n < rel) begin
         step();
         chk("relock_rst_out", 32'(bus.rst_out), 32'(edge_n < rel));
         chk("relock_locked",  32'(bus.locked),  32'(edge_n >= rel));
      end
      m_run = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_start[ch] = rel;
         m_sqb[ch]   = 1'b0;
      end
      check_all("relock_entry");
      run_check(20, "relock");

      // Reset mid-operation
      rst = 1'b1;
      step();
      m_run = 1'b0;
      chk("midrst_clken",   32'(bus.clken),   32'd0);
      chk("midrst_sqclk",   32'(bus.sqclk),   32'd0);
      chk("midrst_locked",  32'(bus.locked),  32'd0);
      chk("midrst_rst_out", 32'(bus.rst_out), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
